// File: rtl/mac_result_serializer_if.sv
// Handshake bundle between a MAC result producer, the serializer and the narrow result bus.
// The master modport drives words in and accepts beats; the slave side is the serializer.
interface mac_result_serializer_if #(
    parameter int unsigned MAC_CONF_WIDTH = 2,
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [MAC_INT_WIDTH-1:0]  in_data;
    logic [MAC_CONF_WIDTH-1:0] in_cfg;
    logic                      out_valid;
    logic                      out_ready;
    logic [MAC_MIN_WIDTH-1:0]  out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_data, in_cfg, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_cfg, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mac_result_serializer.sv
// Serializes one wide MAC result into byte beats, LSB first, with a cfg-dependent beat count.
// A new word can be taken on the last beat's accept, giving one beat per cycle sustained.
module mac_result_serializer #(
    parameter int unsigned MAC_CONF_WIDTH = 2,
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int unsigned CNT_WIDTH      = 3
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      en,
    mac_result_serializer_if.slave   bus
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [MAC_INT_WIDTH-1:0] shreg_q, shreg_d;

    logic in_acc;
    logic out_acc;

    // Index of the final beat: reserved cfg falls back to single.
    function automatic logic [CNT_WIDTH-1:0] last_idx(input logic [MAC_CONF_WIDTH-1:0] cfg);
        case (cfg)
            MAC_CONF_WIDTH'(1): last_idx = CNT_WIDTH'(3);
            MAC_CONF_WIDTH'(2): last_idx = CNT_WIDTH'(4);
            default:            last_idx = CNT_WIDTH'(1);
        endcase
    endfunction

    always_comb begin
        bus.out_valid = (state_q == StSend);
        bus.out_last  = (state_q == StSend) && (cnt_q == '0);
        bus.out_data  = shreg_q[MAC_MIN_WIDTH-1:0];
        // Gated by rst so the handshake is refused during the reset cycle itself.
        if (state_q == StIdle) begin
            bus.in_ready = rst;
        end else begin
            bus.in_ready = rst & bus.out_ready & bus.out_last;
        end
        in_acc  = en & bus.in_valid & bus.in_ready;
        out_acc = en & bus.out_valid & bus.out_ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (in_acc) begin
            shreg_d = bus.in_data;
            cnt_d   = last_idx(bus.in_cfg);
            state_d = StSend;
        end else if (out_acc) begin
            if (cnt_q != '0) begin
                shreg_d = shreg_q >> MAC_MIN_WIDTH;
                cnt_d   = cnt_q - CNT_WIDTH'(1);
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Bench for mac_result_serializer: table-driven words plus hand-written corner sequences,
// with expected beats queued on input accept and checked as the DUT emits them.
module tb_mac_result_serializer;

    localparam int unsigned CW = 2;
    localparam int unsigned MW = 8;
    localparam int unsigned IW = 5 * MW;

    logic clk;
    logic rst;
    logic en;

    mac_result_serializer_if #(
        .MAC_CONF_WIDTH (CW),
        .MAC_MIN_WIDTH  (MW),
        .MAC_INT_WIDTH  (IW)
    ) bus ();

    mac_result_serializer #(
        .MAC_CONF_WIDTH (CW),
        .MAC_MIN_WIDTH  (MW),
        .MAC_INT_WIDTH  (IW),
        .CNT_WIDTH      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [1:0]  cfg;
        logic [39:0] data;
        logic [39:0] exp;
        int          n;
    } vec_t;

    beat_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          cyc = 0;
    int          beat_cyc[int];
    logic [39:0] cur_exp = '0;
    int          cur_n = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: pop on output accept, push on input accept, verify holds under stall.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_data", {56'd0, bus.out_data}, {56'd0, prev_data});
                chk("hold_last", {63'd0, bus.out_last}, {63'd0, prev_last});
            end
            if (en && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {56'd0, bus.out_data}, 64'hFFFF);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_data", {56'd0, bus.out_data}, {56'd0, e.d});
                    chk("beat_last", {63'd0, bus.out_last}, {63'd0, e.l});
                end
                beat_cyc[beats] = cyc;
                beats++;
            end
            if (en && bus.in_valid && bus.in_ready) begin
                for (int i = 0; i < cur_n; i++) begin
                    q.push_back({cur_exp[8*i +: 8], (i == cur_n - 1)});
                end
            end
            hold_prev = bus.out_valid && (!bus.out_ready || !en);
            prev_data = bus.out_data;
            prev_last = bus.out_last;
        end
    end

    // Caller is just after a posedge; returns just after the accepting edge.
    task automatic send(input logic [1:0] cfg, input logic [39:0] data,
                        input logic [39:0] exp, input int n);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_cfg   = cfg;
        bus.in_data  = data;
        cur_exp      = exp;
        cur_n        = n;
        guard        = 0;
        @(negedge clk);
        while (!(en && bus.in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 40'hDE_ADDE_ADDE;
        bus.in_cfg   = 2'b11;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((bus.out_valid || q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        int guard;
        guard = 0;
        while (beats < target && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 100) chk("beat_timeout", 64'd1, 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int b0;
        vecs[0] = '{cfg: 2'b00, data: 40'h00_0000_BEEF, exp: 40'h00_0000_BEEF, n: 2};
        vecs[1] = '{cfg: 2'b10, data: 40'h12_3456_789A, exp: 40'h12_3456_789A, n: 5};
        vecs[2] = '{cfg: 2'b01, data: 40'h00_DEAD_C0DE, exp: 40'h00_DEAD_C0DE, n: 4};
        vecs[3] = '{cfg: 2'b11, data: 40'hFF_FFFF_1234, exp: 40'h00_0000_1234, n: 2};
        vecs[4] = '{cfg: 2'b00, data: 40'hAB_CDEF_0102, exp: 40'h00_0000_0102, n: 2};
        vecs[5] = '{cfg: 2'b01, data: 40'hFF_1122_3344, exp: 40'h00_1122_3344, n: 4};

        rst = 1'b0;
        en = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cfg    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, bus.out_data}, 64'd0);
        chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Single word: consecutive beats, ready again right after the last one.
        b0 = beats;
        send(2'b00, 40'h00_0000_BEEF, 40'h00_0000_BEEF, 2);
        wait_beats(b0 + 2);
        @(negedge clk);
        chk("single_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
        chk("single_valid_after", {63'd0, bus.out_valid}, 64'd0);
        chk("single_gap", 64'(beat_cyc[b0 + 1] - beat_cyc[b0]), 64'd1);
        @(posedge clk);
        #1;

        // Two quad words back to back with no bubble.
        b0 = beats;
        send(2'b10, 40'h12_3456_789A, 40'h12_3456_789A, 5);
        send(2'b10, 40'h12_3456_789A, 40'h12_3456_789A, 5);
        wait_idle();
        chk("b2b_beats", 64'(beats - b0), 64'd10);
        chk("b2b_span", 64'(beat_cyc[b0 + 9] - beat_cyc[b0]), 64'd9);

        // Backpressure pattern on a dual word.
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            b0 = beats;
            send(2'b01, 40'h00_DEAD_C0DE, 40'h00_DEAD_C0DE, 4);
            for (int i = 6; i >= 0; i--) begin
                bus.out_ready = pat[i];
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
            chk("bp_beats", 64'(beats - b0), 64'd4);
            wait_idle();
        end

        // Clock enable low mid-word: nothing moves, stream resumes at the same beat.
        b0 = beats;
        send(2'b01, 40'h00_5566_7788, 40'h00_5566_7788, 4);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("en_no_beats", 64'(beats - b0), 64'd1);
        en = 1'b1;
        wait_idle();
        chk("en_total_beats", 64'(beats - b0), 64'd4);

        // Reset after the second beat of a quad word.
        b0 = beats;
        send(2'b10, 40'h12_3456_789A, 40'h12_3456_789A, 5);
        wait_beats(b0 + 2);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_out_data", {56'd0, bus.out_data}, 64'd0);
        chk("midrst_out_last", {63'd0, bus.out_last}, 64'd0);
        chk("midrst_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
        chk("midrst_beats", 64'(beats - b0), 64'd2);
        @(posedge clk);
        #1;
        b0 = beats;
        send(2'b00, 40'h00_0000_A55A, 40'h00_0000_A55A, 2);
        wait_idle();
        chk("midrst_new_beats", 64'(beats - b0), 64'd2);

        // Table of words, each followed by an idle gap.
        for (int v = 0; v < 6; v++) begin
            b0 = beats;
            send(vecs[v].cfg, vecs[v].data, vecs[v].exp, vecs[v].n);
            wait_idle();
            chk("vec_beats", 64'(beats - b0), 64'(vecs[v].n));
        end

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
